seq_detector: RTL
=================

Name: seq_detector

Overview:
Parametrised serial pattern detector. This is the next generation of the fixed "two consecutive ones" FSM: the target pattern, its length and the overlap mode are now parameters. Samples a 1-bit serial input on qualified clock edges and flags each occurrence of a LEN-bit pattern with a one-cycle pulse. Also keeps a saturating match counter and exposes fill/armed status for downstream control logic.

Parameters:
LEN, 4, pattern length in bits; legal range 2..32 (elaboration error outside range)
PATTERN, 4'b1101, target pattern, LEN bits wide; MSB is the oldest bit received
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match
CNT_W, 8, width of the match counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  sample qualifier; a is consumed only on edges where en=1
a  input  1  serial data bit
clr  input  1  synchronous clear of history, fill, counter and match
match  output  1  one-cycle pulse: pattern completed by the last sampled bit
armed  output  1  high when fill == LEN (a full window is held)
fill  output  $clog2(LEN+1)  number of valid bits in the history window
match_cnt  output  CNT_W  saturating count of matches since reset/clr

Behaviour:
- Reset (rst_n=0, async): hist=0, fill=0, match=0, match_cnt=0, armed=0. On release, the first sample is taken at the first edge with en=1.
- Priority at each edge: clr > en. With clr=1: hist, fill, match and match_cnt all go to 0, and a is ignored.
- Sample (en=1, clr=0): hist_n = {hist[LEN-2:0], a}; fill_n = min(fill+1, LEN).
- Hit condition: hit = (fill_n == LEN) && (hist_n == PATTERN).
- match is registered. It equals hit on sampling edges and 0 otherwise. Latency: match is high in the cycle immediately after the edge that samples the final pattern bit, and never lasts more than one cycle per sample.
- On hit with OVERLAP=0: fill_n is forced to 0. hist still shifts. The next match therefore needs LEN fresh samples.
- On hit with OVERLAP=1: fill stays at LEN, so a suffix of one match may form the prefix of the next.
- en=0: hist, fill and match_cnt hold; match=0.
- match_cnt increments on each hit and saturates at 2^CNT_W-1 (no wrap).
- armed = (fill == LEN), derived combinationally from the fill register.
- Reset asserted mid-stream aborts any partial pattern. No match is produced for bits sampled before reset.

Optional Feature:
Macro SEQ_DET_CNT_EN.
- Defined: match_cnt counter is implemented as described above.
- Undefined: no counter flops are built and match_cnt is tied to 0. All other behaviour is identical.

Test Plan:
- LEN=4, PATTERN=1101, OVERLAP=1; stream 1,1,0,1,1,0,1 with en=1 every cycle -> match pulses after bits 4 and 7; match_cnt=2; armed from bit 4 onward.
- Same stream with OVERLAP=0 -> match pulse only after bit 4; fill returns to 0 after bit 4 and reads 3 after bit 7; match_cnt=1.
- Stream 1,1,0,1 with en=0 cycles inserted between bits (a toggling randomly during gaps) -> exactly one match, one cycle after the 4th qualified bit; fill holds during the gaps.
- CNT_W=2, OVERLAP=0, pattern sent 5 times back-to-back -> 5 match pulses; match_cnt reads 1,2,3,3,3.
- Send 1,1,0, then pulse rst_n low asynchronously (between edges), release, send 1 -> no match; fill=1, match_cnt=0.
- clr=1 and en=1 on the edge that would complete 1101 -> no match; fill=0, match_cnt=0. Without SEQ_DET_CNT_EN, match_cnt is always 0 in every scenario above.

Source files
------------

// File: rtl/seq_detector.sv
// Parametrised serial pattern detector with overlap control, fill/armed status
// and an optional saturating match counter (built only when SEQ_DET_CNT_EN is defined).
module seq_detector #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = LEN'(4'b1101),
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     a,
  input  logic                     clr,
  output logic                     match,
  output logic                     armed,
  output logic [$clog2(LEN+1)-1:0] fill,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int             FILL_W   = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
  localparam bit             OVL      = (OVERLAP != 0);

  generate
    if ((LEN < 2) || (LEN > 32)) begin : g_bad_len
      $error("seq_detector: LEN must lie in 2..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("seq_detector: CNT_W must be at least 1");
    end
  endgenerate

  logic [LEN-1:0]    hist_r;
  logic [LEN-1:0]    hist_s;
  logic [LEN-1:0]    shift_s;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_s;
  logic [FILL_W-1:0] fill_inc_s;
  logic              match_r;
  logic              match_s;
  logic              hit_s;

  // Next-state for history window, fill level and match pulse
  always_comb begin
    hist_s     = hist_r;
    fill_s     = fill_r;
    match_s    = 1'b0;
    hit_s      = 1'b0;
    shift_s    = {hist_r[LEN-2:0], a};
    fill_inc_s = (fill_r == FILL_FULL) ? fill_r : (fill_r + FILL_W'(1));
    if (clr) begin
      hist_s = {LEN{1'b0}};
      fill_s = {FILL_W{1'b0}};
    end else if (en) begin
      hit_s   = (fill_inc_s == FILL_FULL) && (shift_s == PATTERN);
      hist_s  = shift_s;
      match_s = hit_s;
      // Non-overlapping mode restarts the window so the next hit needs LEN fresh bits
      if (hit_s && !OVL) begin
        fill_s = {FILL_W{1'b0}};
      end else begin
        fill_s = fill_inc_s;
      end
    end else begin
      hist_s = hist_r;
      fill_s = fill_r;
    end
  end

  // History, fill and match registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r  <= {LEN{1'b0}};
      fill_r  <= {FILL_W{1'b0}};
      match_r <= 1'b0;
    end else begin
      hist_r  <= hist_s;
      fill_r  <= fill_s;
      match_r <= match_s;
    end
  end

`ifdef SEQ_DET_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  // Saturating match counter next-state
  always_comb begin
    cnt_s = cnt_r;
    if (clr) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (hit_s && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Match counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign match_cnt = cnt_r;
`else
  assign match_cnt = {CNT_W{1'b0}};
`endif

  assign match = match_r;
  assign fill  = fill_r;
  assign armed = (fill_r == FILL_FULL);

endmodule
